ram_fifo: RTL and testbench
===========================

RAM_FIFO -- requirements
Module: ram_fifo

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 4, meaning log2 of storage depth (DEPTH = 2**ADDRESS_WIDTH entries).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the width of each stored word.
REQ-003 SHALL have parameter ALMOST_FULL_LEVEL, default 2**ADDRESS_WIDTH - 2, meaning the count at or above which almostFull asserts.
REQ-004 SHALL have parameter ALMOST_EMPTY_LEVEL, default 2, meaning the count at or below which almostEmpty asserts.
REQ-005 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-007 SHALL have port wrEn  input  1  meaning write request.
REQ-008 SHALL have port din  input  DATA_WIDTH  meaning write data.
REQ-009 SHALL have port rdEn  input  1  meaning read request.
REQ-010 SHALL have port dout  output  DATA_WIDTH  meaning registered read data.
REQ-011 SHALL have port doutValid  output  1  meaning dout holds a word popped on the previous edge.
REQ-012 SHALL have ports full, empty, almostFull, almostEmpty  output  1 each  meaning occupancy flags.
REQ-013 SHALL have port count  output  ADDRESS_WIDTH+1  meaning number of stored words, 0..DEPTH.
REQ-014 SHALL have ports overflow, underflow  output  1 each  meaning sticky error flags.
REQ-015 SHALL have port clrErr  input  1  meaning synchronous clear of overflow and underflow.

Function
REQ-016 SHALL store words in an internal dual-port array of DEPTH x DATA_WIDTH, one write and one read port, no storage reset.
REQ-017 SHALL accept a write iff wrEn=1 and full=0; accepted write stores din at write pointer and increments it modulo DEPTH.
REQ-018 SHALL accept a read iff rdEn=1 and empty=0; accepted read registers array[read pointer] into dout and increments read pointer modulo DEPTH.
REQ-019 SHALL have read latency 1: doutValid=1 in the cycle after an accepted read, else 0; dout holds its last value when no read is accepted.
REQ-020 SHALL update count +1 for write-only accept, -1 for read-only accept, unchanged for simultaneous accept or no accept.
REQ-021 SHALL, when full and both wrEn and rdEn asserted, accept the read only (write rejected, overflow set).
REQ-022 SHALL, when empty and both asserted, accept the write only (read rejected, underflow set); the written word is not bypassed to dout.
REQ-023 SHALL derive full=(count==DEPTH), empty=(count==0), almostFull=(count>=ALMOST_FULL_LEVEL), almostEmpty=(count<=ALMOST_EMPTY_LEVEL) from the registered count, so flags change the cycle after the causing edge.
REQ-024 SHALL set overflow on any edge with wrEn=1 and full=1, and underflow on any edge with rdEn=1 and empty=1; both remain set until clrErr or reset.
REQ-025 SHALL give a set event priority over clrErr in the same cycle.
REQ-026 SHALL leave pointers, count and array unchanged on rejected requests.
REQ-027 SHALL wrap pointers from DEPTH-1 to 0 with no loss of data ordering (strict FIFO order).

Reset
REQ-028 SHALL on rst=1 immediately clear pointers, count, dout, doutValid, overflow, underflow, independent of clk.
REQ-029 SHALL present after reset: empty=1, full=0, almostEmpty=1, almostFull=0 (given ALMOST_FULL_LEVEL>0).
REQ-030 SHALL discard all stored words on reset asserted mid-operation; the first read after release returns only data written after release.

Verification (ADDRESS_WIDTH=3, DATA_WIDTH=8, ALMOST_FULL_LEVEL=6, ALMOST_EMPTY_LEVEL=1)
REQ-031 SHALL cover: reset, write 0x11,0x22,0x33, read 3 -> dout 0x11,0x22,0x33 each one cycle after its read, doutValid=1 those cycles, count returns 0, empty=1.
REQ-032 SHALL cover: write 8 words 0x00..0x07 -> count=8, full=1, almostFull=1 from count 6; 9th write 0xFF -> overflow=1, count stays 8, later reads return 0x00..0x07.
REQ-033 SHALL cover: rdEn on empty FIFO -> underflow=1, doutValid=0, dout unchanged; clrErr pulse -> underflow=0; clrErr with simultaneous underflow event -> underflow stays 1.
REQ-034 SHALL cover: at count=4, wrEn and rdEn together for 12 cycles with incrementing data -> count stays 4, pointers wrap, read data in exact write order.
REQ-035 SHALL cover: full FIFO with wrEn+rdEn together -> read accepted, write rejected, count=7, overflow=1; empty FIFO with both -> count=1, underflow=1, doutValid=0.
REQ-036 SHALL cover: rst asserted between clock edges at count=5 -> outputs clear without a clock edge; write 0xAA then read -> dout=0xAA.

Source files
------------

// File: rtl/ram_fifo.sv
// Synchronous FIFO on a simple dual-port array with registered read data,
// occupancy flags derived from a registered count, and sticky error flags.
module ram_fifo #(
  parameter int ADDRESS_WIDTH      = 4,
  parameter int DATA_WIDTH         = 8,
  parameter int ALMOST_FULL_LEVEL  = 2**ADDRESS_WIDTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wrEn,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   rdEn,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   doutValid,
  output logic                   full,
  output logic                   empty,
  output logic                   almostFull,
  output logic                   almostEmpty,
  output logic [ADDRESS_WIDTH:0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clrErr
);

  localparam int DEPTH = 2**ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_CNT = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0] AF_LEVEL  = (ADDRESS_WIDTH+1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDRESS_WIDTH:0] AE_LEVEL  = (ADDRESS_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr_reg;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_reg;
  logic [ADDRESS_WIDTH:0]   count_reg;
  logic [ADDRESS_WIDTH:0]   count_next;
  logic [DATA_WIDTH-1:0]    dout_reg;
  logic                     dout_valid_reg;
  logic                     overflow_reg;
  logic                     underflow_reg;
  logic                     wr_accept;
  logic                     rd_accept;

  // Full blocks writes and empty blocks reads, which yields read-only
  // acceptance when full and write-only acceptance when empty.
  assign wr_accept = wrEn && !full;
  assign rd_accept = rdEn && !empty;

  always_comb begin
    count_next = count_reg;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      count_reg      <= count_next;
      dout_valid_reg <= rd_accept;
      if (wr_accept)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        dout_reg   <= mem[rd_ptr_reg];
      end
      // A new error event wins over a clear in the same cycle.
      if (wrEn && full)
        overflow_reg <= 1'b1;
      else if (clrErr)
        overflow_reg <= 1'b0;
      if (rdEn && empty)
        underflow_reg <= 1'b1;
      else if (clrErr)
        underflow_reg <= 1'b0;
    end
  end

  assign dout        = dout_reg;
  assign doutValid   = dout_valid_reg;
  assign count       = count_reg;
  assign full        = (count_reg == DEPTH_CNT);
  assign empty       = (count_reg == '0);
  assign almostFull  = (count_reg >= AF_LEVEL);
  assign almostEmpty = (count_reg <= AE_LEVEL);
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

endmodule

// File: tb/tb_ram_fifo.sv
// Directed bench for ram_fifo at depth 8: ordering, flags, errors, wrap and
// asynchronous reset, each compared against hand-computed values.
module tb_ram_fifo;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wrEn = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rdEn = 1'b0;
  logic          clrErr = 1'b0;
  logic [DW-1:0] dout;
  logic          doutValid;
  logic          full, empty, almostFull, almostEmpty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int checks = 0;
  int errors = 0;

  ram_fifo #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ALMOST_FULL_LEVEL(6),
    .ALMOST_EMPTY_LEVEL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wrEn(wrEn),
    .din(din),
    .rdEn(rdEn),
    .dout(dout),
    .doutValid(doutValid),
    .full(full),
    .empty(empty),
    .almostFull(almostFull),
    .almostEmpty(almostEmpty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow),
    .clrErr(clrErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One clock with the given request inputs; returns 1 ns after the edge.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    wrEn = w; din = d; rdEn = r; clrErr = c;
    @(posedge clk);
    #1;
    wrEn = 1'b0; rdEn = 1'b0; clrErr = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_aempty", 32'(almostEmpty), 1);
    check("rst_afull", 32'(almostFull), 0);
    check("rst_valid", 32'(doutValid), 0);
    check("rst_errs", 32'({overflow, underflow}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic ordering with one-cycle read latency
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h22, 0, 0);
    cycle(1, 8'h33, 0, 0);
    check("b_count3", 32'(count), 3);
    check("b_aempty", 32'(almostEmpty), 0);
    cycle(0, 0, 1, 0);
    check("b_dout0", 32'(dout), 32'h11);
    check("b_valid0", 32'(doutValid), 1);
    cycle(0, 0, 1, 0);
    check("b_dout1", 32'(dout), 32'h22);
    cycle(0, 0, 1, 0);
    check("b_dout2", 32'(dout), 32'h33);
    check("b_valid2", 32'(doutValid), 1);
    check("b_empty", 32'(empty), 1);
    check("b_count0", 32'(count), 0);
    cycle(0, 0, 0, 0);
    check("b_idle_valid", 32'(doutValid), 0);
    check("b_idle_dout", 32'(dout), 32'h33);

    // Fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      cycle(1, 8'(i), 0, 0);
      check($sformatf("f_count%0d", i + 1), 32'(count), 32'(i + 1));
      check($sformatf("f_afull%0d", i + 1), 32'(almostFull), (i + 1 >= 6) ? 1 : 0);
    end
    check("f_full", 32'(full), 1);
    cycle(1, 8'hFF, 0, 0);
    check("f_ovf", 32'(overflow), 1);
    check("f_ovf_count", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 0);
      check($sformatf("f_rd%0d", i), 32'(dout), 32'(i));
    end
    check("f_empty", 32'(empty), 1);
    cycle(0, 0, 0, 1);
    check("f_ovf_clr", 32'(overflow), 0);

    // Underflow and clear priority
    cycle(0, 0, 1, 0);
    check("u_unf", 32'(underflow), 1);
    check("u_valid", 32'(doutValid), 0);
    check("u_dout", 32'(dout), 32'h07);
    cycle(0, 0, 0, 1);
    check("u_clr", 32'(underflow), 0);
    cycle(0, 0, 1, 1);
    check("u_set_wins", 32'(underflow), 1);
    cycle(0, 0, 0, 1);
    check("u_clr2", 32'(underflow), 0);

    // Steady-state simultaneous traffic across the wrap point
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 12; i++) begin
      cycle(1, 8'(8'h44 + i), 1, 0);
      check($sformatf("s_rd%0d", i), 32'(dout), 32'(8'h40 + i));
      check($sformatf("s_cnt%0d", i), 32'(count), 4);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0);
      check($sformatf("s_drain%0d", i), 32'(dout), 32'(8'h4C + i));
    end
    check("s_empty", 32'(empty), 1);

    // Both requests at full, then at empty
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h80 + i), 0, 0);
    cycle(1, 8'hEE, 1, 0);
    check("x_full_dout", 32'(dout), 32'h80);
    check("x_full_count", 32'(count), 7);
    check("x_full_ovf", 32'(overflow), 1);
    for (int i = 1; i < 8; i++) begin
      cycle(0, 0, 1, 0);
      check($sformatf("x_drain%0d", i), 32'(dout), 32'(8'h80 + i));
    end
    cycle(0, 0, 0, 1);
    cycle(1, 8'h99, 1, 0);
    check("x_empty_count", 32'(count), 1);
    check("x_empty_unf", 32'(underflow), 1);
    check("x_empty_valid", 32'(doutValid), 0);
    check("x_empty_dout", 32'(dout), 32'h87);
    cycle(0, 0, 1, 1);
    check("x_rd99", 32'(dout), 32'h99);

    // Asynchronous reset between edges
    for (int i = 0; i < 6; i++) cycle(1, 8'(8'h60 + i), 0, 0);
    cycle(0, 0, 1, 0);
    check("r_pre_count", 32'(count), 5);
    check("r_pre_valid", 32'(doutValid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("r_count", 32'(count), 0);
    check("r_empty", 32'(empty), 1);
    check("r_valid", 32'(doutValid), 0);
    check("r_dout", 32'(dout), 0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 8'hAA, 0, 0);
    cycle(0, 0, 1, 0);
    check("r_rdAA", 32'(dout), 32'hAA);
    check("r_end_empty", 32'(empty), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
